// File: rtl/dda_stepper_pkg.sv
// Shared types and constants for the DDA ray stepper and its divider.
package dda_stepper_pkg;

    localparam int unsigned QWidth      = 16;
    localparam int unsigned FracBits    = 8;
    localparam int unsigned BromLatency = 2;
    localparam int unsigned DivWidth    = 24;

    typedef enum logic [2:0] {
        StIdle,
        StStep,
        StFetch,
        StCheck,
        StDivide,
        StWallx,
        StOutput
    } state_e;

endpackage

// File: rtl/dda_stepper_divider.sv
// Unsigned 24/16 restoring divider, one quotient bit per cycle.
module dda_stepper_divider
    import dda_stepper_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [DivWidth-1:0] dividend_i,
    input  logic [QWidth-1:0]   divisor_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [DivWidth-1:0] quotient_o
);

    logic [QWidth-1:0]   rem_q;
    logic [QWidth-1:0]   dvs_q;
    logic [DivWidth-1:0] quo_q;
    logic [4:0]          cnt_q;
    logic [QWidth:0]     rem_sh;
    logic [QWidth:0]     diff;
    logic                fits;

    always_comb begin
        rem_sh = {rem_q, quo_q[DivWidth-1]};
        fits   = rem_sh >= {1'b0, dvs_q};
        diff   = rem_sh - {1'b0, dvs_q};
    end

    // The dividend is shifted out of quo_q as quotient bits are shifted in.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_o <= 1'b0;
            done_o <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            done_o <= 1'b0;
            if (busy_o) begin
                rem_q <= fits ? QWidth'(diff) : QWidth'(rem_sh);
                quo_q <= {quo_q[DivWidth-2:0], fits};
                cnt_q <= cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
            end else if (start_i) begin
                busy_o <= 1'b1;
                cnt_q  <= 5'(DivWidth);
                rem_q  <= '0;
                quo_q  <= dividend_i;
                dvs_q  <= divisor_i;
            end
        end
    end

    assign quotient_o = quo_q;

endmodule

// File: rtl/dda_stepper.sv
// Per-column DDA raycaster: walks the map grid until a wall hit or escape, then
// produces wall height and texture coordinate for the flattening stage.
module dda_stepper
    import dda_stepper_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 240,
    parameter int unsigned N             = 24
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic              ray_valid_in,
    output logic              ray_ready_out,
    input  logic [7:0]        hcount_in,
    input  logic [7:0]        mapX_in,
    input  logic [7:0]        mapY_in,
    input  logic              stepX_in,
    input  logic              stepY_in,
    input  logic [QWidth-1:0] sideDistX_in,
    input  logic [QWidth-1:0] sideDistY_in,
    input  logic [QWidth-1:0] deltaDistX_in,
    input  logic [QWidth-1:0] deltaDistY_in,
    input  logic [QWidth-1:0] posX_in,
    input  logic [QWidth-1:0] posY_in,
    input  logic [QWidth-1:0] rayDirX_in,
    input  logic [QWidth-1:0] rayDirY_in,
    output logic [9:0]        map_addr_out,
    input  logic [7:0]        map_data_in,
    output logic [7:0]        hcount_ray_out,
    output logic [QWidth-1:0] lineHeight_out,
    output logic              wallType_out,
    output logic [7:0]        mapData_out,
    output logic [QWidth-1:0] wallX_out,
    output logic              valid_out,
    input  logic              ready_in
);

    localparam logic [DivWidth-1:0] Dividend = DivWidth'(SCREEN_HEIGHT << FracBits);
    localparam logic [7:0]          MaxSteps = 8'(2 * N);
    localparam logic [7:0]          LastCell = 8'(N - 1);

    state_e            state_q;
    logic [7:0]        hcount_q, map_x_q, map_y_q, cell_q, steps_q;
    logic              step_x_q, step_y_q, side_q;
    logic [QWidth-1:0] side_x_q, side_y_q, delta_x_q, delta_y_q;
    logic [QWidth-1:0] pos_x_q, pos_y_q, dir_x_q, dir_y_q, perp_q, lh_q;
    logic [1:0]        wait_q;

    logic                take_x, at_edge;
    logic [7:0]          map_x_nxt, map_y_nxt;
    logic [15:0]         addr_full;
    logic [QWidth:0]     sum_x, sum_y;
    logic [QWidth-1:0]   sat_x, sat_y, wall_sum, height;
    logic signed [32:0]  perp_s, dir_s, prod;
    logic                div_start, div_busy, div_done;
    logic [DivWidth-1:0] div_quotient;

    always_comb begin
        take_x    = side_x_q < side_y_q;
        map_x_nxt = map_x_q;
        map_y_nxt = map_y_q;
        if (take_x) begin
            map_x_nxt = step_x_q ? map_x_q - 8'd1 : map_x_q + 8'd1;
        end else begin
            map_y_nxt = step_y_q ? map_y_q - 8'd1 : map_y_q + 8'd1;
        end
        addr_full = 16'(map_y_nxt) * 16'(N) + 16'(map_x_nxt);
        sum_x     = {1'b0, side_x_q} + {1'b0, delta_x_q};
        sum_y     = {1'b0, side_y_q} + {1'b0, delta_y_q};
        sat_x     = sum_x[QWidth] ? 16'hFFFF : sum_x[QWidth-1:0];
        sat_y     = sum_y[QWidth] ? 16'hFFFF : sum_y[QWidth-1:0];
        at_edge   = (map_x_q == 8'd0) || (map_x_q == LastCell) ||
                    (map_y_q == 8'd0) || (map_y_q == LastCell);
        // X hits sample the wall along Y and vice versa; Q16.16 product back to Q8.8.
        perp_s    = 33'($signed({1'b0, perp_q}));
        dir_s     = 33'($signed(side_q ? dir_x_q : dir_y_q));
        prod      = perp_s * dir_s;
        wall_sum  = (side_q ? pos_x_q : pos_y_q) + 16'(prod >>> FracBits);
        height    = ((perp_q < 16'h0100) || (div_quotient > DivWidth'(SCREEN_HEIGHT))) ?
                    16'(SCREEN_HEIGHT) : 16'(div_quotient);
        div_start = (state_q == StDivide) && !div_busy && !div_done;
    end

    dda_stepper_divider u_divider (
        .clk_i      (pixel_clk_in),
        .rst_i      (rst_in),
        .start_i    (div_start),
        .dividend_i (Dividend),
        .divisor_i  (perp_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quotient)
    );

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q        <= StIdle;
            ray_ready_out  <= 1'b0;
            valid_out      <= 1'b0;
            map_addr_out   <= '0;
            hcount_ray_out <= '0;
            lineHeight_out <= '0;
            wallType_out   <= 1'b0;
            mapData_out    <= '0;
            wallX_out      <= '0;
            steps_q        <= '0;
            wait_q         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ray_ready_out <= 1'b1;
                    if (ray_valid_in && ray_ready_out) begin
                        ray_ready_out <= 1'b0;
                        hcount_q      <= hcount_in;
                        map_x_q       <= mapX_in;
                        map_y_q       <= mapY_in;
                        step_x_q      <= stepX_in;
                        step_y_q      <= stepY_in;
                        side_x_q      <= sideDistX_in;
                        side_y_q      <= sideDistY_in;
                        delta_x_q     <= deltaDistX_in;
                        delta_y_q     <= deltaDistY_in;
                        pos_x_q       <= posX_in;
                        pos_y_q       <= posY_in;
                        dir_x_q       <= rayDirX_in;
                        dir_y_q       <= rayDirY_in;
                        steps_q       <= '0;
                        state_q       <= StStep;
                    end
                end
                StStep: begin
                    if (take_x) begin
                        side_x_q <= sat_x;
                        map_x_q  <= map_x_nxt;
                        side_q   <= 1'b0;
                    end else begin
                        side_y_q <= sat_y;
                        map_y_q  <= map_y_nxt;
                        side_q   <= 1'b1;
                    end
                    map_addr_out <= 10'(addr_full);
                    steps_q      <= steps_q + 8'd1;
                    wait_q       <= '0;
                    state_q      <= StFetch;
                end
                StFetch: begin
                    wait_q <= wait_q + 2'd1;
                    if (wait_q == 2'(BromLatency - 1)) state_q <= StCheck;
                end
                StCheck: begin
                    if (map_data_in != 8'd0) begin
                        cell_q  <= map_data_in;
                        perp_q  <= side_q ? side_y_q - delta_y_q : side_x_q - delta_x_q;
                        state_q <= StDivide;
                    end else if ((steps_q >= MaxSteps) || at_edge) begin
                        hcount_ray_out <= hcount_q;
                        wallType_out   <= side_q;
                        mapData_out    <= '0;
                        lineHeight_out <= '0;
                        wallX_out      <= '0;
                        valid_out      <= 1'b1;
                        state_q        <= StOutput;
                    end else begin
                        state_q <= StStep;
                    end
                end
                StDivide: begin
                    if (div_done) begin
                        lh_q    <= height;
                        state_q <= StWallx;
                    end
                end
                StWallx: begin
                    hcount_ray_out <= hcount_q;
                    wallType_out   <= side_q;
                    mapData_out    <= cell_q;
                    lineHeight_out <= lh_q;
                    wallX_out      <= wall_sum & 16'h00FF;
                    valid_out      <= 1'b1;
                    state_q        <= StOutput;
                end
                StOutput: begin
                    if (ready_in) begin
                        valid_out     <= 1'b0;
                        ray_ready_out <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in && ray_valid_in && ray_ready_out) begin
            assert (32'(hcount_in) < SCREEN_WIDTH);
        end
    end

endmodule

// File: tb/tb_dda_stepper.sv
// Directed bench for dda_stepper with a 2-cycle map BROM model.
module tb_dda_stepper;
    import dda_stepper_pkg::*;

    logic        clk = 1'b0;
    logic        rst, ray_valid, ray_ready;
    logic [7:0]  hcount, map_x, map_y;
    logic        step_x, step_y;
    logic [15:0] side_x, side_y, delta_x, delta_y, pos_x, pos_y, dir_x, dir_y;
    logic [9:0]  map_addr;
    logic [7:0]  map_data;
    logic [7:0]  hc_out, md_out;
    logic [15:0] lh_out, wx_out;
    logic        wt_out, valid, rdy;

    logic [7:0]  mem [0:1023];
    logic [7:0]  rd1, rd2;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd1 <= mem[map_addr];
        rd2 <= rd1;
    end
    assign map_data = rd2;

    dda_stepper dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst),
        .ray_valid_in   (ray_valid),
        .ray_ready_out  (ray_ready),
        .hcount_in      (hcount),
        .mapX_in        (map_x),
        .mapY_in        (map_y),
        .stepX_in       (step_x),
        .stepY_in       (step_y),
        .sideDistX_in   (side_x),
        .sideDistY_in   (side_y),
        .deltaDistX_in  (delta_x),
        .deltaDistY_in  (delta_y),
        .posX_in        (pos_x),
        .posY_in        (pos_y),
        .rayDirX_in     (dir_x),
        .rayDirY_in     (dir_y),
        .map_addr_out   (map_addr),
        .map_data_in    (map_data),
        .hcount_ray_out (hc_out),
        .lineHeight_out (lh_out),
        .wallType_out   (wt_out),
        .mapData_out    (md_out),
        .wallX_out      (wx_out),
        .valid_out      (valid),
        .ready_in       (rdy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_map();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    task automatic set_ray(input logic [7:0] hc, input logic [7:0] mx, input logic [7:0] my,
                           input logic sx, input logic sy,
                           input logic [15:0] sdx, input logic [15:0] sdy,
                           input logic [15:0] ddx, input logic [15:0] ddy,
                           input logic [15:0] dx, input logic [15:0] dy);
        hcount = hc; map_x = mx; map_y = my; step_x = sx; step_y = sy;
        side_x = sdx; side_y = sdy; delta_x = ddx; delta_y = ddy;
        pos_x = 16'h0280; pos_y = 16'h0280; dir_x = dx; dir_y = dy;
    endtask

    task automatic send_ray(input string tag);
        bit ok = 1'b0;
        ray_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ray_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        ray_valid = 1'b0;
        check({tag, "_accept"}, 64'(ok), 64'(1));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_valid"}, 64'(ok), 64'(1));
    endtask

    task automatic check_result(input string tag, input logic [7:0] hc, input logic [15:0] lh,
                                input logic wt, input logic [7:0] md, input logic [15:0] wx);
        check({tag, "_hcount"}, 64'(hc_out), 64'(hc));
        check({tag, "_lineheight"}, 64'(lh_out), 64'(lh));
        check({tag, "_walltype"}, 64'(wt_out), 64'(wt));
        check({tag, "_mapdata"}, 64'(md_out), 64'(md));
        check({tag, "_wallx"}, 64'(wx_out), 64'(wx));
    endtask

    task automatic release_result(input string tag);
        rdy = 1'b1;
        @(negedge clk);
        check({tag, "_valid_dropped"}, 64'(valid), 64'(0));
        check({tag, "_back_idle"}, 64'(ray_ready), 64'(1));
        rdy = 1'b0;
    endtask

    initial begin
        clear_map();
        rst = 1'b1; ray_valid = 1'b0; rdy = 1'b0;
        set_ray(8'h00, 8'd2, 8'd2, 1'b0, 1'b0, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF,
                16'h0100, 16'h0000);
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(ray_ready), 64'(0));
        check("reset_valid", 64'(valid), 64'(0));
        check("reset_addr", 64'(map_addr), 64'(0));
        check("reset_outputs", 64'({hc_out, lh_out, wt_out, md_out, wx_out}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(ray_ready), 64'(1));

        // Three X steps from (2,2) to the wall at (5,2); perp 2.5 -> 61440/640 = 96.
        mem[2*24+5] = 8'd7;
        set_ray(8'h2A, 8'd2, 8'd2, 1'b0, 1'b0, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF,
                16'h0100, 16'h0000);
        send_ray("basic");
        wait_valid("basic", 100);
        check_result("basic", 8'h2A, 16'd96, 1'b0, 8'd7, 16'h0080);
        check("basic_addr", 64'(map_addr), 64'(2*24+5));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(valid), 64'(1));
            check("hold_outputs", 64'({hc_out, lh_out, wt_out, md_out, wx_out}),
                  64'({8'h2A, 16'd96, 1'b0, 8'd7, 16'h0080}));
        end
        release_result("basic");

        // Tie takes the Y step; wallX = 0x0280 + 1.0 * -0.25 -> fraction 0x40.
        clear_map();
        mem[3*24+2] = 8'd3;
        set_ray(8'h10, 8'd2, 8'd2, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
                16'hFFC0, 16'h0100);
        send_ray("tie");
        wait_valid("tie", 100);
        check_result("tie", 8'h10, 16'd240, 1'b1, 8'd3, 16'h0040);
        release_result("tie");

        // Adjacent wall in -X direction, perp 0x0040 forces full height.
        clear_map();
        mem[2*24+1] = 8'd9;
        set_ray(8'h05, 8'd2, 8'd2, 1'b1, 1'b0, 16'h0040, 16'hFFFF, 16'h0100, 16'hFFFF,
                16'h0100, 16'h0080);
        send_ray("near");
        wait_valid("near", 100);
        check_result("near", 8'h05, 16'd240, 1'b0, 8'd9, 16'h00A0);
        release_result("near");

        // Both side distances saturate; perp 0xFEFF gives height 0.
        clear_map();
        mem[3*24+3] = 8'd5;
        set_ray(8'h33, 8'd2, 8'd2, 1'b0, 1'b0, 16'hFF80, 16'hFFF0, 16'h0100, 16'h0100,
                16'h0000, 16'h0000);
        send_ray("sat");
        wait_valid("sat", 100);
        check_result("sat", 8'h33, 16'd0, 1'b1, 8'd5, 16'h0080);
        release_result("sat");

        // Empty map: escape once mapX reaches the last column (23).
        clear_map();
        set_ray(8'h77, 8'd2, 8'd2, 1'b0, 1'b0, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF,
                16'h0100, 16'h0000);
        send_ray("escape");
        wait_valid("escape", 300);
        check_result("escape", 8'h77, 16'd0, 1'b0, 8'd0, 16'h0000);
        check("escape_addr", 64'(map_addr), 64'(2*24+23));
        release_result("escape");

        // Reset while dividing abandons the ray; the next ray completes normally.
        mem[2*24+5] = 8'd7;
        set_ray(8'h2A, 8'd2, 8'd2, 1'b0, 1'b0, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF,
                16'h0100, 16'h0000);
        send_ray("abort");
        repeat (19) @(negedge clk);
        check("abort_in_divide", 64'(dut.state_q), 64'(StDivide));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 64'(valid), 64'(0));
        check("abort_state", 64'(dut.state_q), 64'(StIdle));
        check("abort_div_busy", 64'(dut.div_busy), 64'(0));
        check("abort_addr", 64'(map_addr), 64'(0));
        clear_map();
        mem[2*24+1] = 8'd9;
        set_ray(8'h06, 8'd2, 8'd2, 1'b1, 1'b0, 16'h0040, 16'hFFFF, 16'h0100, 16'hFFFF,
                16'h0100, 16'h0080);
        send_ray("after_abort");
        wait_valid("after_abort", 100);
        check_result("after_abort", 8'h06, 16'd240, 1'b0, 8'd9, 16'h00A0);
        release_result("after_abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
